// File: rtl/ahbl_slave_mem.sv
// AHB-Lite responder backed by a word-organised little-endian RAM, with programmable
// wait states and a two-cycle ERROR response for out-of-range, oversize or misaligned transfers.
module ahbl_slave_mem #(
    parameter int MEM_ADDR_BITS = 12,
    parameter int WAIT_STATES   = 0,
    parameter int TPD           = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int DEPTH = 2 ** (MEM_ADDR_BITS - 2);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                   state_reg, state_next;
    logic [3:0]               count_reg, count_next;
    logic [MEM_ADDR_BITS-1:0] addr_reg;
    logic                     write_reg;
    logic [2:0]               size_reg;
    logic                     err_reg;
    logic [31:0]              mem [DEPTH];

    logic                     can_accept;
    logic                     accept;
    logic                     addr_err;
    logic                     mem_we;
    logic [3:0]               lane_en;
    logic [MEM_ADDR_BITS-3:0] word_idx;
    logic                     unused;

    // Burst, protection and lock attributes carry no meaning for a plain RAM target.
    assign unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], (TPD != 0)};

    assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
    assign addr_err   = (HADDR[31:MEM_ADDR_BITS] != '0)
                     || (HSIZE > 3'd2)
                     || ((HSIZE == 3'd1) && HADDR[0])
                     || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    assign word_idx = addr_reg[MEM_ADDR_BITS-1:2];

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            size_reg  <= 3'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                addr_reg  <= HADDR[MEM_ADDR_BITS-1:0];
                write_reg <= HWRITE;
                size_reg  <= HSIZE;
                err_reg   <= addr_err;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            S_WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = S_DATA;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            S_ERR1: state_next = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all end on a ready edge where a new transfer may start.
                if (accept) begin
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        count_next = WAIT_LOAD;
                    end else begin
                        state_next = S_DATA;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = !((state_reg == S_WAIT) || (state_reg == S_ERR1));
        HRESP     = (state_reg == S_ERR1) || (state_reg == S_ERR2);
        HRDATA    = '0;
        if ((state_reg == S_DATA) && !write_reg) begin
            HRDATA = mem[word_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = (size_reg == 3'd0) ? (addr_reg[1:0] == 2'(gi))
                               : (size_reg == 3'd1) ? (addr_reg[1] == (gi >= 2))
                               : 1'b1;
        end
    endgenerate

    // A reset edge landing on the closing DATA edge drops the pending write.
    assign mem_we = HRESETN && (state_reg == S_DATA) && write_reg && !err_reg;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Bench for ahbl_slave_mem: two instances (0 and 3 wait states) driven by a pipelined
// AHB-Lite master task and checked against constants and a byte-level RAM model.
module tb_ahbl_slave_mem;
    logic        clk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [3:0]  hprot = 4'h3;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0;

    logic [31:0] rdata0, rdata1, rdata_m;
    logic        ready0, ready1, ready_m;
    logic        resp0, resp1, resp_m;
    logic        hsel0, hsel1, hready;
    int          dsel = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
    } op_t;

    op_t         ops[$];
    logic [31:0] res_rdata [128];
    int          res_low [128];
    int          res_errlow [128];
    logic        res_resp [128];

    always #5 clk = ~clk;

    assign hsel0   = hsel && (dsel == 0);
    assign hsel1   = hsel && (dsel == 1);
    assign ready_m = (dsel == 1) ? ready1 : ready0;
    assign resp_m  = (dsel == 1) ? resp1 : resp0;
    assign rdata_m = (dsel == 1) ? rdata1 : rdata0;
    assign hready  = ready_m;

    ahbl_slave_mem #(.MEM_ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahbl_slave_mem #(.MEM_ADDR_BITS(12), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(hready), .HWDATA(hwdata),
        .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
    );

    function automatic void push(bit sel, bit [1:0] trans, bit write, bit [31:0] addr,
                                 bit [2:0] size, bit [31:0] wdata);
        ops.push_back('{sel, trans, write, addr, size, wdata});
    endfunction

    function automatic void nseq(bit write, bit [31:0] addr, bit [2:0] size, bit [31:0] wdata);
        push(1'b1, 2'b10, write, addr, size, wdata);
    endfunction

    // Pipelined master: each op's address phase is offered while the previous data phase runs.
    task automatic run_ops();
        int n = ops.size();
        int ai = 0;
        int di = -1;
        int cyc = 0;
        bit done = 1'b0;
        for (int k = 0; k < n; k++) begin
            res_low[k] = 0; res_errlow[k] = 0; res_resp[k] = 1'b0; res_rdata[k] = '0;
        end
        while (!done) begin
            if (ai < n) begin
                hsel = ops[ai].sel; htrans = ops[ai].trans; hwrite = ops[ai].write;
                haddr = ops[ai].addr; hsize = ops[ai].size;
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd0;
            end
            hwdata = (di >= 0) ? ops[di].wdata : 32'h0;
            @(negedge clk);
            if (di >= 0) begin
                if (!ready_m) begin
                    res_low[di]++;
                    if (resp_m) res_errlow[di]++;
                end else begin
                    res_resp[di]  = resp_m;
                    res_rdata[di] = rdata_m;
                end
            end
            if (ready_m) begin
                di = (ai < n) ? ai : -1;
                if (ai < n) ai++;
                if (di < 0) done = 1'b1;
            end
            cyc++;
            if (!done && cyc > 20 * n + 50) begin
                checks++; errors++;
                $display("FAIL bus_timeout: got %0d cycles required at most %0d", cyc, 20 * n + 50);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            dsel = d; #1;
            checks++;
            if (ready_m !== 1'b1) begin errors++; $display("FAIL reset_hreadyout dut%0d: got %b required 1", d, ready_m); end
            checks++;
            if (resp_m !== 1'b0) begin errors++; $display("FAIL reset_hresp dut%0d: got %b required 0", d, resp_m); end
            checks++;
            if (rdata_m !== 32'h0) begin errors++; $display("FAIL reset_hrdata dut%0d: got %h required 0", d, rdata_m); end
        end
        @(posedge clk); #1;
        hresetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_rw();
        dsel = 0;
        ops.delete();
        nseq(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        nseq(1'b0, 32'h10, 3'd2, 32'h0);
        run_ops();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (res_low[k] !== 0) begin errors++; $display("FAIL b2b_low op%0d: got %0d required 0", k, res_low[k]); end
            checks++;
            if (res_resp[k] !== 1'b0) begin errors++; $display("FAIL b2b_resp op%0d: got %b required 0", k, res_resp[k]); end
        end
        checks++;
        if (res_rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata: got %h required deadbeef", res_rdata[1]); end
    endtask

    task automatic test_byte_lanes();
        dsel = 0;
        ops.delete();
        nseq(1'b1, 32'h20, 3'd2, 32'h11223344);
        nseq(1'b1, 32'h21, 3'd0, {8'($urandom), 8'($urandom), 8'hAA, 8'($urandom)});
        nseq(1'b1, 32'h22, 3'd1, {16'h5566, 16'($urandom)});
        nseq(1'b0, 32'h20, 3'd2, 32'h0);
        run_ops();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (res_resp[k] !== 1'b0) begin errors++; $display("FAIL lanes_resp op%0d: got %b required 0", k, res_resp[k]); end
        end
        checks++;
        if (res_rdata[3] !== 32'h5566AA44) begin errors++; $display("FAIL lanes_rdata: got %h required 5566aa44", res_rdata[3]); end
    endtask

    task automatic test_wait_states();
        dsel = 1;
        ops.delete();
        nseq(1'b1, 32'h10, 3'd2, 32'h13579BDF);
        nseq(1'b0, 32'h10, 3'd2, 32'h0);
        run_ops();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (res_low[k] !== 3) begin errors++; $display("FAIL wait_low op%0d: got %0d required 3", k, res_low[k]); end
            checks++;
            if (res_errlow[k] !== 0 || res_resp[k] !== 1'b0) begin
                errors++; $display("FAIL wait_resp op%0d: got %0d/%b required 0/0", k, res_errlow[k], res_resp[k]);
            end
        end
        checks++;
        if (res_rdata[1] !== 32'h13579BDF) begin errors++; $display("FAIL wait_rdata: got %h required 13579bdf", res_rdata[1]); end
    endtask

    task automatic test_errors(input int d);
        int ws = (d == 1) ? 3 : 0;
        dsel = d;
        ops.delete();
        nseq(1'b1, 32'h0, 3'd2, 32'hCAFEF00D);
        nseq(1'b1, 32'h1000, 3'd2, 32'h12345678);
        nseq(1'b1, 32'h3, 3'd1, 32'hFFFFFFFF);
        nseq(1'b0, 32'h0, 3'd2, 32'h0);
        run_ops();
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (res_low[k] !== 1 || res_errlow[k] !== 1) begin
                errors++; $display("FAIL err1 dut%0d op%0d: got low=%0d errlow=%0d required 1/1", d, k, res_low[k], res_errlow[k]);
            end
            checks++;
            if (res_resp[k] !== 1'b1) begin errors++; $display("FAIL err2 dut%0d op%0d: got %b required 1", d, k, res_resp[k]); end
            checks++;
            if (res_rdata[k] !== 32'h0) begin errors++; $display("FAIL err_rdata dut%0d op%0d: got %h required 0", d, k, res_rdata[k]); end
        end
        checks++;
        if (res_low[3] !== ws || res_resp[3] !== 1'b0) begin
            errors++; $display("FAIL err_after dut%0d: got low=%0d resp=%b required %0d/0", d, res_low[3], res_resp[3], ws);
        end
        checks++;
        if (res_rdata[3] !== 32'hCAFEF00D) begin errors++; $display("FAIL err_ram dut%0d: got %h required cafef00d", d, res_rdata[3]); end
    endtask

    task automatic test_no_transfer();
        dsel = 0;
        ops.delete();
        nseq(1'b1, 32'h30, 3'd2, 32'h0F1E2D3C);
        push(1'b1, 2'b00, 1'b1, 32'h30, 3'd2, $urandom);
        push(1'b1, 2'b01, 1'b1, 32'h30, 3'd2, $urandom);
        push(1'b0, 2'b10, 1'b1, 32'h30, 3'd2, $urandom);
        nseq(1'b0, 32'h30, 3'd2, 32'h0);
        run_ops();
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (res_low[k] !== 0 || res_resp[k] !== 1'b0) begin
                errors++; $display("FAIL notx op%0d: got low=%0d resp=%b required 0/0", k, res_low[k], res_resp[k]);
            end
        end
        checks++;
        if (res_rdata[4] !== 32'h0F1E2D3C) begin errors++; $display("FAIL notx_ram: got %h required 0f1e2d3c", res_rdata[4]); end
    endtask

    task automatic test_reset_mid();
        dsel = 1;
        ops.delete();
        nseq(1'b1, 32'h40, 3'd2, 32'h0BADF00D);
        run_ops();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = 32'h99999999;
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b0) begin errors++; $display("FAIL rstmid_wait1: got %b required 0", ready_m); end
        @(posedge clk); #1;
        hresetn = 1'b0;
        @(posedge clk); #1;
        hresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b1) begin errors++; $display("FAIL rstmid_hreadyout: got %b required 1", ready_m); end
        checks++;
        if (resp_m !== 1'b0) begin errors++; $display("FAIL rstmid_hresp: got %b required 0", resp_m); end
        @(posedge clk); #1;
        ops.delete();
        nseq(1'b0, 32'h40, 3'd2, 32'h0);
        run_ops();
        checks++;
        if (res_rdata[0] !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_ram: got %h required 0badf00d", res_rdata[0]); end
    endtask

    task automatic test_random(input int d);
        logic [31:0] model [16];
        int          exp_low [128];
        bit          exp_resp [128];
        bit          exp_rchk [128];
        logic [31:0] exp_rdata [128];
        int          ws = (d == 1) ? 3 : 0;
        int          n, kind, sz, w, lane;
        bit [31:0]   a, wd;
        bit          wr;
        dsel = d;
        ops.delete();
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            n = ops.size();
            nseq(1'b1, 32'h100 + 32'(4 * i), 3'd2, model[i]);
            exp_low[n] = ws; exp_resp[n] = 1'b0; exp_rchk[n] = 1'b0; exp_rdata[n] = '0;
        end
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            sz   = $urandom_range(0, 2);
            w    = $urandom_range(0, 15);
            a    = 32'h100 + 32'(4 * w) + 32'($urandom_range(0, 3) & ~((1 << sz) - 1));
            wd   = $urandom;
            wr   = 1'($urandom_range(0, 1));
            n    = ops.size();
            if (kind < 6) begin
                nseq(wr, a, 3'(sz), wd);
                if (wr) begin
                    for (int b = 0; b < (1 << sz); b++) begin
                        lane = int'((a + 32'(b)) % 4);
                        model[w][8*lane +: 8] = wd[8*lane +: 8];
                    end
                end
                exp_low[n] = ws; exp_resp[n] = 1'b0; exp_rchk[n] = !wr; exp_rdata[n] = model[w];
            end else if (kind < 8) begin
                case ($urandom_range(0, 2))
                    0: begin a = (32'($urandom_range(1, 1048575)) << 12) | (a & 32'hFFC); sz = 2; end
                    1: begin
                        if (sz == 0) sz = 1;
                        a = (sz == 1) ? (a | 32'h1) : {a[31:2], 2'($urandom_range(1, 3))};
                    end
                    default: sz = $urandom_range(3, 7);
                endcase
                nseq(wr, a, 3'(sz), wd);
                exp_low[n] = 1; exp_resp[n] = 1'b1; exp_rchk[n] = 1'b1; exp_rdata[n] = '0;
            end else begin
                if ($urandom_range(0, 1) == 0) push(1'b0, 2'b10, wr, a, 3'(sz), wd);
                else push(1'b1, 2'($urandom_range(0, 1)), wr, a, 3'(sz), wd);
                exp_low[n] = 0; exp_resp[n] = 1'b0; exp_rchk[n] = 1'b1; exp_rdata[n] = '0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            n = ops.size();
            nseq(1'b0, 32'h100 + 32'(4 * i), 3'd2, 32'h0);
            exp_low[n] = ws; exp_resp[n] = 1'b0; exp_rchk[n] = 1'b1; exp_rdata[n] = model[i];
        end
        run_ops();
        for (int k = 0; k < ops.size(); k++) begin
            checks++;
            if (res_low[k] !== exp_low[k]) begin
                errors++; $display("FAIL rnd_low dut%0d op%0d addr=%h: got %0d required %0d", d, k, ops[k].addr, res_low[k], exp_low[k]);
            end
            checks++;
            if (res_errlow[k] !== (exp_resp[k] ? exp_low[k] : 0) || res_resp[k] !== exp_resp[k]) begin
                errors++; $display("FAIL rnd_resp dut%0d op%0d addr=%h: got %0d/%b required resp %b", d, k, ops[k].addr, res_errlow[k], res_resp[k], exp_resp[k]);
            end
            if (exp_rchk[k]) begin
                checks++;
                if (res_rdata[k] !== exp_rdata[k]) begin
                    errors++; $display("FAIL rnd_rdata dut%0d op%0d addr=%h: got %h required %h", d, k, ops[k].addr, res_rdata[k], exp_rdata[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_errors(0);
        test_errors(1);
        test_no_transfer();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
